// File: rtl/cart_rom_reader_if.sv
// Request/response handshake between the splash generator (master) and the
// cartridge ROM reader (slave).
interface cart_rom_reader_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd;
  logic              rom_bsy;
  logic [7:0]        rom_data;

  modport master (
    output rom_addr, rom_rd,
    input  rom_bsy, rom_data
  );

  modport slave (
    input  rom_addr, rom_rd,
    output rom_bsy, rom_data
  );
endinterface

// File: rtl/cart_rom_reader.sv
// Turns each rising edge of rom_rd into one timed read cycle on the cartridge
// bus (setup, strobe, sample) and returns the byte on rom_data.
module cart_rom_reader #(
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 4,
  parameter int ADDR_W     = 16
) (
  input  logic              clk_8m,
  input  logic              rst_n,
  cart_rom_reader_if.slave  rom,
  input  logic              bus_grant,
  output logic              bus_active,
  output logic [ADDR_W-1:0] cart_a,
  input  logic [7:0]        cart_d,
  output logic              cart_rd_n
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    SETUP,
    STROBE
  } state_e;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] ACCESS_LD = 8'(ACCESS_CYC - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              bsy_q, bsy_d;
  logic              rd_q;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] cart_a_q, cart_a_d;
  logic              rd_n_q, rd_n_d;
  logic              active_q, active_d;
  logic              rd_rise;

  assign rd_rise = rom.rom_rd & ~rd_q;

  // Combinational term lets the requester see busy in the request cycle itself.
  assign rom.rom_bsy  = bsy_q | (rd_rise & (state_q == IDLE));
  assign rom.rom_data = data_q;
  assign cart_a       = cart_a_q;
  assign cart_rd_n    = rd_n_q;
  assign bus_active   = active_q;

  always_comb begin
    // NOTE: every signal gets a default hold value first so no path through
    // the case statement leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    bsy_d    = bsy_q;
    data_d   = data_q;
    cart_a_d = cart_a_q;
    rd_n_d   = rd_n_q;
    active_d = active_q;

    unique case (state_q)
      IDLE: begin
        if (rd_rise) begin
          cart_a_d = rom.rom_addr;
          bsy_d    = 1'b1;
          cnt_d    = SETUP_LD;
          if (bus_grant) begin
            state_d  = SETUP;
            active_d = 1'b1;
          end else begin
            state_d  = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        if (bus_grant) begin
          state_d  = SETUP;
          active_d = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          rd_n_d  = 1'b0;
          cnt_d   = ACCESS_LD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        // cart_d is sampled on the last strobe edge; cart_a stays put afterwards
        // to give the cartridge address hold time.
        if (cnt_q == 8'd0) begin
          data_d   = cart_d;
          rd_n_d   = 1'b1;
          bsy_d    = 1'b0;
          active_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      bsy_q    <= 1'b0;
      rd_q     <= 1'b0;
      data_q   <= 8'h00;
      cart_a_q <= '0;
      rd_n_q   <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bsy_q    <= bsy_d;
      rd_q     <= rom.rom_rd;
      data_q   <= data_d;
      cart_a_q <= cart_a_d;
      rd_n_q   <= rd_n_d;
      active_q <= active_d;
    end
  end

endmodule
